led_frame_buffer_ctrl: RTL and testbench

Ping-pong frame-buffer controller that sequences one simple dual-port RAM of depth 2×PIXELS between the HDMI pixel-capture stream and the APA102 pixel serializer. The capture side writes one frame into the free bank while the serializer side streams the other bank out through a valid/ready interface. Banks swap only on complete frames. The capture stream has no backpressure, so whole frames are dropped, and flagged, when no bank is free.

---
 rtl/led_frame_buffer_ctrl_if.sv | 35 +++
 rtl/led_frame_buffer_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_led_frame_buffer_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_buffer_ctrl_if.sv
// Bundle of capture stream, serializer stream and RAM port signals for the ping-pong frame buffer.
// master = controller side, slave = capture/serializer/RAM side.
// Widths follow SIZE (pixel word) and AW = $clog2(2*PIXELS) (RAM address).
interface led_frame_buffer_ctrl_if #(
    parameter int SIZE   = 24,
    parameter int PIXELS = 64
);
    localparam int AW = $clog2(2 * PIXELS);

    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_frame_start;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            frame_dropped;
    logic [AW-1:0]   ram_waddr;
    logic [SIZE-1:0] ram_wdata;
    logic            ram_we;
    logic [AW-1:0]   ram_raddr;
    logic [SIZE-1:0] ram_rdata;

    modport master (
        input  in_data, in_valid, in_frame_start, out_ready, ram_rdata,
        output out_data, out_valid, out_last, frame_dropped,
               ram_waddr, ram_wdata, ram_we, ram_raddr
    );

    modport slave (
        output in_data, in_valid, in_frame_start, out_ready, ram_rdata,
        input  out_data, out_valid, out_last, frame_dropped,
               ram_waddr, ram_wdata, ram_we, ram_raddr
    );
endinterface

// File: rtl/led_frame_buffer_ctrl.sv
// Ping-pong frame buffer: capture writes one RAM bank while the serializer streams the other.
// Latency: last captured pixel to first out_valid is 4 edges; 1 pixel/cycle while out_ready is high.
// Backpressure: capture side has none (whole frames dropped when no bank is free); output is valid/ready.
module led_frame_buffer_ctrl #(
    parameter int SIZE   = 24,
    parameter int PIXELS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    led_frame_buffer_ctrl_if.master bus
);
    localparam int AW = $clog2(2 * PIXELS);
    localparam int CW = $clog2(PIXELS);
    localparam logic [CW-1:0] LAST_OFF   = CW'(PIXELS - 1);
    localparam logic [AW-1:0] BANK1_BASE = AW'(PIXELS);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DRAIN} rstate_t;

    // Writer state
    wstate_t         w_state_q;
    logic [CW-1:0]   wcnt_q;
    logic            wbank_q;
    logic            ram_we_q;
    logic [AW-1:0]   ram_waddr_q;
    logic [SIZE-1:0] ram_wdata_q;
    logic            drop_q;
    logic            commit_q;
    logic            commit_bank_q;
    logic [AW-1:0]   wbase;

    // Bank ownership
    logic [1:0]      full_q;
    logic [1:0]      full_d;

    // Reader state
    rstate_t         r_state_q;
    logic [CW-1:0]   rcnt_q;
    logic            rbank_q;
    logic [AW-1:0]   ram_raddr_q;
    logic            rd_p1_q;
    logic            rd_p2_q;
    logic            last_p1_q;
    logic            last_p2_q;
    logic [AW-1:0]   rbase;

    // Output queue: three slots cover the two-cycle read pipeline plus the head being presented,
    // so the issue credit can keep one pixel per cycle flowing without ever overflowing.
    logic [SIZE-1:0] obuf_dat_q  [3];
    logic            obuf_last_q [3];
    logic [1:0]      head_q;
    logic [1:0]      tail_q;
    logic [1:0]      occ_q;

    logic            out_vld;
    logic            pop;
    logic            head_last;
    logic            rd_clear;
    logic [2:0]      pending;
    logic            can_issue;
    logic            issue_now;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign wbase = wbank_q ? BANK1_BASE : '0;
    assign rbase = rbank_q ? BANK1_BASE : '0;

    assign out_vld   = (occ_q != 2'd0);
    assign pop       = out_vld && bus.out_ready;
    assign head_last = obuf_last_q[head_q];
    assign rd_clear  = (r_state_q == R_DRAIN) && pop && head_last;
    assign pending   = {1'b0, occ_q} + {2'b00, rd_p1_q} + {2'b00, rd_p2_q};
    // A pop this cycle frees a slot, so it counts as credit for a new read.
    assign can_issue = pop ? (pending < 3'd4) : (pending < 3'd3);
    assign issue_now = ((r_state_q == R_IDLE) && full_q[rbank_q]) ||
                       ((r_state_q == R_STREAM) && can_issue);

    // Writer FSM: frame-start decides fill vs skip; the last pixel schedules a commit one edge later,
    // coincident with its RAM write.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q     <= W_IDLE;
            wcnt_q        <= '0;
            wbank_q       <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_waddr_q   <= '0;
            ram_wdata_q   <= '0;
            drop_q        <= 1'b0;
            commit_q      <= 1'b0;
            commit_bank_q <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            drop_q   <= 1'b0;
            commit_q <= 1'b0;
            if (bus.in_valid && bus.in_frame_start) begin
                // Any partial frame is abandoned; this pixel is offset 0 of a new frame.
                if (!full_q[wbank_q]) begin
                    ram_we_q    <= 1'b1;
                    ram_waddr_q <= wbase;
                    ram_wdata_q <= bus.in_data;
                    wcnt_q      <= CW'(1);
                    w_state_q   <= W_FILL;
                end else begin
                    drop_q    <= 1'b1;
                    wcnt_q    <= '0;
                    w_state_q <= W_SKIP;
                end
            end else if (bus.in_valid && (w_state_q == W_FILL)) begin
                ram_we_q    <= 1'b1;
                ram_waddr_q <= wbase + AW'(wcnt_q);
                ram_wdata_q <= bus.in_data;
                if (wcnt_q == LAST_OFF) begin
                    commit_q      <= 1'b1;
                    commit_bank_q <= wbank_q;
                    wbank_q       <= ~wbank_q;
                    wcnt_q        <= '0;
                    w_state_q     <= W_IDLE;
                end else begin
                    wcnt_q <= wcnt_q + CW'(1);
                end
            end
        end
    end

    // Full flags: writer sets and reader clears always target different banks, so both apply.
    always_comb begin
        full_d = full_q;
        if (commit_q) full_d[commit_bank_q] = 1'b1;
        if (rd_clear) full_d[rbank_q] = 1'b0;
    end

    // Full flag register.
    always_ff @(posedge clk) begin
        if (rst) full_q <= 2'b00;
        else     full_q <= full_d;
    end

    // Reader FSM: issues reads into a two-stage pipeline tagged with the last-pixel marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            rcnt_q      <= '0;
            rbank_q     <= 1'b0;
            ram_raddr_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            last_p1_q   <= 1'b0;
            last_p2_q   <= 1'b0;
        end else begin
            rd_p1_q   <= 1'b0;
            rd_p2_q   <= rd_p1_q;
            last_p2_q <= last_p1_q;
            if (issue_now) begin
                ram_raddr_q <= rbase + AW'(rcnt_q);
                rd_p1_q     <= 1'b1;
                last_p1_q   <= (rcnt_q == LAST_OFF);
                rcnt_q      <= (rcnt_q == LAST_OFF) ? '0 : rcnt_q + CW'(1);
            end
            case (r_state_q)
                R_IDLE:   if (issue_now) r_state_q <= R_STREAM;
                R_STREAM: if (issue_now && (rcnt_q == LAST_OFF)) r_state_q <= R_DRAIN;
                R_DRAIN: begin
                    if (rd_clear) begin
                        rbank_q   <= ~rbank_q;
                        r_state_q <= R_IDLE;
                    end
                end
                default:  r_state_q <= R_IDLE;
            endcase
        end
    end

    // Output queue: RAM data lands two edges after issue; the head is held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                obuf_dat_q[i]  <= '0;
                obuf_last_q[i] <= 1'b0;
            end
            head_q <= 2'd0;
            tail_q <= 2'd0;
            occ_q  <= 2'd0;
        end else begin
            if (rd_p2_q) begin
                obuf_dat_q[tail_q]  <= bus.ram_rdata;
                obuf_last_q[tail_q] <= last_p2_q;
                tail_q              <= nxt(tail_q);
            end
            if (pop) head_q <= nxt(head_q);
            case ({rd_p2_q, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign bus.out_data      = obuf_dat_q[head_q];
    assign bus.out_valid     = out_vld;
    assign bus.out_last      = out_vld && head_last;
    assign bus.frame_dropped = drop_q;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_waddr     = ram_waddr_q;
    assign bus.ram_wdata     = ram_wdata_q;
    assign bus.ram_raddr     = ram_raddr_q;
endmodule

// File: tb/tb_led_frame_buffer_ctrl.sv
// Directed bench for led_frame_buffer_ctrl: PIXELS=4 instance for most cases, PIXELS=5 for bank wrap.
module tb_led_frame_buffer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_frame_buffer_ctrl_if #(.SIZE(8), .PIXELS(4)) bus4 ();
    led_frame_buffer_ctrl_if #(.SIZE(8), .PIXELS(5)) bus5 ();

    led_frame_buffer_ctrl #(.SIZE(8), .PIXELS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    led_frame_buffer_ctrl #(.SIZE(8), .PIXELS(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

    // RAM models: synchronous write, registered read.
    logic [7:0] mem4 [8];
    logic [7:0] mem5 [10];
    always @(posedge clk) begin
        if (bus4.ram_we) mem4[bus4.ram_waddr] <= bus4.ram_wdata;
        bus4.ram_rdata <= mem4[bus4.ram_raddr];
        if (bus5.ram_we) mem5[bus5.ram_waddr] <= bus5.ram_wdata;
        bus5.ram_rdata <= mem5[bus5.ram_raddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitors (sampled on the falling edge)
    logic [7:0] od4_q[$];
    logic       ol4_q[$];
    int         oc4_q[$];
    int         wa4_q[$];
    logic [7:0] od5_q[$];
    logic       ol5_q[$];
    int         oc5_q[$];
    int         wa5_q[$];
    int         drop4 = 0, drop5 = 0, wcount4 = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_dat  = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus4.out_valid && bus4.out_ready) begin
                od4_q.push_back(bus4.out_data); ol4_q.push_back(bus4.out_last); oc4_q.push_back(cyc);
            end
            if (bus4.ram_we) begin wa4_q.push_back(int'(bus4.ram_waddr)); wcount4++; end
            if (bus4.frame_dropped) drop4++;
            if (bus5.out_valid && bus5.out_ready) begin
                od5_q.push_back(bus5.out_data); ol5_q.push_back(bus5.out_last); oc5_q.push_back(cyc);
            end
            if (bus5.ram_we) wa5_q.push_back(int'(bus5.ram_waddr));
            if (bus5.frame_dropped) drop5++;
            if (stall_prev) begin
                check_eq("stall_vld", 32'(bus4.out_valid), 32'd1);
                check_eq("stall_dat", 32'(bus4.out_data), 32'(stall_dat));
            end
        end
        stall_prev = !rst && bus4.out_valid && !bus4.out_ready;
        stall_dat  = bus4.out_data;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_q();
        od4_q.delete(); ol4_q.delete(); oc4_q.delete(); wa4_q.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1; tick(); rst = 1'b0; tick(); clear_q();
    endtask

    task automatic send_frame(input int which, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 4) begin
                bus4.in_valid = 1'b1; bus4.in_frame_start = (i == 0); bus4.in_data = base + 8'(i);
            end else begin
                bus5.in_valid = 1'b1; bus5.in_frame_start = (i == 0); bus5.in_data = base + 8'(i);
            end
            tick();
        end
        bus4.in_valid = 1'b0; bus4.in_frame_start = 1'b0;
        bus5.in_valid = 1'b0; bus5.in_frame_start = 1'b0;
    endtask

    function automatic int osize(input int which);
        return (which == 4) ? od4_q.size() : od5_q.size();
    endfunction

    task automatic expect_frame(input int which, input logic [7:0] base, input int n, input bit consec);
        int waited = 0;
        int prev_c = 0;
        logic [7:0] d;
        logic l;
        int c;
        while (osize(which) < n && waited < 300) begin @(negedge clk); waited++; end
        check_eq("frame_arrived", 32'(osize(which) >= n), 32'd1);
        if (osize(which) < n) return;
        for (int i = 0; i < n; i++) begin
            if (which == 4) begin d = od4_q.pop_front(); l = ol4_q.pop_front(); c = oc4_q.pop_front(); end
            else            begin d = od5_q.pop_front(); l = ol5_q.pop_front(); c = oc5_q.pop_front(); end
            check_eq("pix_dat", 32'(d), 32'(base + 8'(i)));
            check_eq("pix_last", 32'(l), 32'(i == n - 1));
            if (consec && i > 0) check_eq("pix_gap", 32'(c - prev_c), 32'd1);
            prev_c = c;
        end
    endtask

    task automatic expect_writes(input int which, input int base, input int n);
        int a;
        check_eq("wr_count", 32'((which == 4) ? wa4_q.size() >= n : wa5_q.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (which == 4) a = (wa4_q.size() > 0) ? wa4_q.pop_front() : -1;
            else            a = (wa5_q.size() > 0) ? wa5_q.pop_front() : -1;
            check_eq("wr_addr", 32'(a), 32'(base + i));
        end
    endtask

    int rdy_pat [16] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1};
    logic [7:0] bases5 [4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int wc0;
        int dr0;
        bus4.in_data = '0; bus4.in_valid = 1'b0; bus4.in_frame_start = 1'b0; bus4.out_ready = 1'b0;
        bus5.in_data = '0; bus5.in_valid = 1'b0; bus5.in_frame_start = 1'b0; bus5.out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check_eq("rst_out_last", 32'(bus4.out_last), 32'd0);
        check_eq("rst_out_data", 32'(bus4.out_data), 32'd0);
        check_eq("rst_dropped", 32'(bus4.frame_dropped), 32'd0);
        check_eq("rst_ram_we", 32'(bus4.ram_we), 32'd0);
        check_eq("rst_waddr", 32'(bus4.ram_waddr), 32'd0);
        check_eq("rst_wdata", 32'(bus4.ram_wdata), 32'd0);
        check_eq("rst_raddr", 32'(bus4.ram_raddr), 32'd0);
        tick();

        // Single frame: latency, addresses, back-to-back output
        bus4.out_ready = 1'b1;
        send_frame(4, 8'h10, 4);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (bus4.out_valid) break;
        end
        check_eq("first_latency", 32'(lat), 32'd4);
        expect_frame(4, 8'h10, 4, 1'b1);
        expect_writes(4, 0, 4);
        check_eq("single_drops", 32'(drop4), 32'd0);

        // Ping-pong with stalled output: A->bank0, B->bank1, C dropped
        pulse_reset();
        bus4.out_ready = 1'b0;
        wc0 = wcount4; dr0 = drop4;
        send_frame(4, 8'h40, 4);
        send_frame(4, 8'h50, 4);
        send_frame(4, 8'h60, 4);
        repeat (3) tick();
        check_eq("pp_drop", 32'(drop4 - dr0), 32'd1);
        check_eq("pp_writes", 32'(wcount4 - wc0), 32'd8);
        expect_writes(4, 0, 4);
        expect_writes(4, 4, 4);
        check_eq("pp_no_c_write", 32'(wa4_q.size()), 32'd0);
        check_eq("pp_stall_none", 32'(od4_q.size()), 32'd0);
        bus4.out_ready = 1'b1;
        expect_frame(4, 8'h40, 4, 1'b1);
        expect_frame(4, 8'h50, 4, 1'b1);
        repeat (20) tick();
        check_eq("pp_no_frame_c", 32'(od4_q.size()), 32'd0);

        // Backpressure: toggled ready, data held while stalled
        clear_q();
        fork
            send_frame(4, 8'h70, 4);
            begin
                for (int i = 0; i < 32; i++) begin
                    bus4.out_ready = rdy_pat[i % 16][0];
                    tick();
                end
                bus4.out_ready = 1'b1;
            end
        join
        expect_frame(4, 8'h70, 4, 1'b0);
        repeat (10) tick();
        check_eq("bp_extra", 32'(od4_q.size()), 32'd0);

        // Abandoned partial frame
        dr0 = drop4;
        send_frame(4, 8'h20, 2);
        send_frame(4, 8'h30, 4);
        expect_frame(4, 8'h30, 4, 1'b1);
        repeat (10) tick();
        check_eq("abandon_extra", 32'(od4_q.size()), 32'd0);
        check_eq("abandon_drop", 32'(drop4 - dr0), 32'd0);

        // Reset mid-stream
        clear_q();
        send_frame(4, 8'h80, 4);
        lat = 0;
        while (od4_q.size() < 2 && lat < 50) begin @(negedge clk); lat++; end
        check_eq("mid_two_out", 32'(od4_q.size() >= 2), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_out_valid", 32'(bus4.out_valid), 32'd0);
        check_eq("mid_ram_we", 32'(bus4.ram_we), 32'd0);
        check_eq("mid_raddr", 32'(bus4.ram_raddr), 32'd0);
        tick();
        clear_q();
        repeat (5) tick();
        check_eq("mid_no_resume", 32'(od4_q.size()), 32'd0);
        send_frame(4, 8'h90, 4);
        expect_frame(4, 8'h90, 4, 1'b1);
        expect_writes(4, 0, 4);

        // PIXELS=5: four frames alternate banks 0,1,0,1
        for (int f = 0; f < 4; f++) begin
            send_frame(5, bases5[f], 5);
            repeat (12) tick();
        end
        for (int f = 0; f < 4; f++) begin
            expect_writes(5, (f % 2) * 5, 5);
            expect_frame(5, bases5[f], 5, 1'b1);
        end
        check_eq("p5_drops", 32'(drop5), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
